// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Brief    : ID/EX pipeline register with EX/MEM/WB operand forwarding,
//            load-use stall, branch flush, downstream hold and bubble counter.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  input  logic [XLEN-1:0]   ex_alu_result,
  input  logic [4:0]        mem_rd,
  input  logic              mem_reg_write,
  input  logic [XLEN-1:0]   mem_fwd_data,
  input  logic [4:0]        wb_rd,
  input  logic              wb_reg_write,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              stall_out,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_op1,
  output logic [XLEN-1:0]   ex_op2,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [15:0]       bubble_count
);

  localparam logic [15:0] c_BUBBLE_MAX = 16'hFFFF;

  logic              r_ex_valid;
  logic [XLEN-1:0]   r_ex_pc;
  logic [XLEN-1:0]   r_ex_imm;
  logic [XLEN-1:0]   r_ex_op1;
  logic [XLEN-1:0]   r_ex_op2;
  logic [4:0]        r_ex_rs1;
  logic [4:0]        r_ex_rs2;
  logic [4:0]        r_ex_rd;
  logic              r_ex_reg_write;
  logic              r_ex_mem_read;
  logic [CTRL_W-1:0] r_ex_ctrl;
  logic [15:0]       r_bubble_count;

  logic              w_ex_fwd_en;
  logic              w_lu;
  logic              w_bubble;
  logic [XLEN-1:0]   w_op1;
  logic [XLEN-1:0]   w_op2;

  // A load in EX has no data yet, so it is excluded from EX forwarding.
  assign w_ex_fwd_en = r_ex_valid && r_ex_reg_write && !r_ex_mem_read;

  function automatic logic [XLEN-1:0] f_fwd(
    input logic [4:0]      src,
    input logic [XLEN-1:0] rf_val
  );
    logic [XLEN-1:0] v;
    if (src == 5'd0)
      v = '0;
    else if (w_ex_fwd_en && (r_ex_rd == src))
      v = ex_alu_result;
    else if (mem_reg_write && (mem_rd == src))
      v = mem_fwd_data;
    else if (wb_reg_write && (wb_rd == src))
      v = wb_data;
    else
      v = rf_val;
    return v;
  endfunction

  assign w_op1 = f_fwd(id_rs1, rf_rdata1);
  assign w_op2 = f_fwd(id_rs2, rf_rdata2);

  assign w_lu = r_ex_valid && r_ex_mem_read && r_ex_reg_write && (r_ex_rd != 5'd0) &&
                id_valid && ((id_use_rs1 && (id_rs1 == r_ex_rd)) ||
                             (id_use_rs2 && (id_rs2 == r_ex_rd)));

  assign w_bubble  = flush || w_lu;
  assign stall_out = !rst && (ex_hold || (w_lu && !flush));

  always_ff @(posedge clk) begin
    if (rst || (!ex_hold && w_bubble)) begin
      r_ex_valid     <= 1'b0;
      r_ex_pc        <= '0;
      r_ex_imm       <= '0;
      r_ex_op1       <= '0;
      r_ex_op2       <= '0;
      r_ex_rs1       <= '0;
      r_ex_rs2       <= '0;
      r_ex_rd        <= '0;
      r_ex_reg_write <= 1'b0;
      r_ex_mem_read  <= 1'b0;
      r_ex_ctrl      <= '0;
    end else if (!ex_hold) begin
      r_ex_valid     <= id_valid;
      r_ex_pc        <= id_pc;
      r_ex_imm       <= id_imm;
      r_ex_op1       <= w_op1;
      r_ex_op2       <= w_op2;
      r_ex_rs1       <= id_rs1;
      r_ex_rs2       <= id_rs2;
      r_ex_rd        <= id_rd;
      r_ex_reg_write <= id_valid && id_reg_write;
      r_ex_mem_read  <= id_valid && id_mem_read;
      r_ex_ctrl      <= id_ctrl;
    end
  end

  // Only load-use bubbles are counted; flush bubbles are not stalls.
  always_ff @(posedge clk) begin
    if (rst)
      r_bubble_count <= '0;
    else if (!ex_hold && !flush && w_lu && (r_bubble_count != c_BUBBLE_MAX))
      r_bubble_count <= r_bubble_count + 16'd1;
  end

  assign ex_valid     = r_ex_valid;
  assign ex_pc        = r_ex_pc;
  assign ex_imm       = r_ex_imm;
  assign ex_op1       = r_ex_op1;
  assign ex_op2       = r_ex_op2;
  assign ex_rs1       = r_ex_rs1;
  assign ex_rs2       = r_ex_rs2;
  assign ex_rd        = r_ex_rd;
  assign ex_reg_write = r_ex_reg_write;
  assign ex_mem_read  = r_ex_mem_read;
  assign ex_ctrl      = r_ex_ctrl;
  assign bubble_count = r_bubble_count;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Brief    : Directed plus randomized bench for id_ex_stage with a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
  logic [11:0] id_ctrl;
  logic [31:0] rf_rdata1, rf_rdata2, ex_alu_result;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_fwd_data, wb_data;
  logic        flush, ex_hold;
  logic        stall_out, ex_valid, ex_reg_write, ex_mem_read;
  logic [31:0] ex_pc, ex_imm, ex_op1, ex_op2;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [11:0] ex_ctrl;
  logic [15:0] bubble_count;

  int tests = 0;
  int fails = 0;

  id_ex_stage #(.XLEN(32), .CTRL_W(12)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_ctrl(id_ctrl), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .ex_alu_result(ex_alu_result), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_fwd_data(mem_fwd_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data), .flush(flush), .ex_hold(ex_hold), .stall_out(stall_out),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_op1(ex_op1),
    .ex_op2(ex_op2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_ctrl(ex_ctrl),
    .bubble_count(bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: contents of the EX stage plus the bubble tally.
  typedef struct {
    logic        valid;
    logic [31:0] pc, imm, op1, op2;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mr;
    logic [11:0] ctrl;
  } ex_t;

  ex_t m_ex;
  int  m_cnt;

  // Walk the writers youngest-first and take the first one that produces s.
  function automatic logic [31:0] m_operand(input logic [4:0] s, input logic [31:0] rf);
    logic        en [3];
    logic [4:0]  rd [3];
    logic [31:0] dt [3];
    en[0] = m_ex.valid && m_ex.rw && !m_ex.mr; rd[0] = m_ex.rd; dt[0] = ex_alu_result;
    en[1] = mem_reg_write;                     rd[1] = mem_rd;  dt[1] = mem_fwd_data;
    en[2] = wb_reg_write;                      rd[2] = wb_rd;   dt[2] = wb_data;
    if (s == 5'd0) return 32'd0;
    for (int i = 0; i < 3; i++)
      if (en[i] && rd[i] == s) return dt[i];
    return rf;
  endfunction

  function automatic logic m_lu();
    logic hit;
    hit = (id_use_rs1 && id_rs1 == m_ex.rd) || (id_use_rs2 && id_rs2 == m_ex.rd);
    return m_ex.valid && m_ex.mr && m_ex.rw && (m_ex.rd != 5'd0) && id_valid && hit;
  endfunction

  function automatic logic m_stall();
    return !rst && (ex_hold || (m_lu() && !flush));
  endfunction

  function automatic ex_t m_next();
    ex_t nx;
    nx = m_ex;
    if (rst || (!ex_hold && (flush || m_lu()))) begin
      nx = '{valid: 1'b0, pc: 32'd0, imm: 32'd0, op1: 32'd0, op2: 32'd0,
             rs1: 5'd0, rs2: 5'd0, rd: 5'd0, rw: 1'b0, mr: 1'b0, ctrl: 12'd0};
    end else if (!ex_hold) begin
      nx = '{valid: id_valid, pc: id_pc, imm: id_imm,
             op1: m_operand(id_rs1, rf_rdata1), op2: m_operand(id_rs2, rf_rdata2),
             rs1: id_rs1, rs2: id_rs2, rd: id_rd,
             rw: id_valid && id_reg_write, mr: id_valid && id_mem_read, ctrl: id_ctrl};
    end
    return nx;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("ex_valid", {31'd0, ex_valid}, {31'd0, m_ex.valid});
    check("ex_pc", ex_pc, m_ex.pc);
    check("ex_imm", ex_imm, m_ex.imm);
    check("ex_op1", ex_op1, m_ex.op1);
    check("ex_op2", ex_op2, m_ex.op2);
    check("ex_rs1", {27'd0, ex_rs1}, {27'd0, m_ex.rs1});
    check("ex_rs2", {27'd0, ex_rs2}, {27'd0, m_ex.rs2});
    check("ex_rd", {27'd0, ex_rd}, {27'd0, m_ex.rd});
    check("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, m_ex.rw});
    check("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, m_ex.mr});
    check("ex_ctrl", {20'd0, ex_ctrl}, {20'd0, m_ex.ctrl});
    check("bubble_count", {16'd0, bubble_count}, m_cnt[31:0]);
  endtask

  // One clock: check stall before the edge, advance model, check outputs after.
  task automatic step();
    ex_t nx;
    logic lu_cnt;
    #1;
    check("stall_out", {31'd0, stall_out}, {31'd0, m_stall()});
    nx = m_next();
    lu_cnt = !rst && !ex_hold && !flush && m_lu();
    @(posedge clk);
    if (rst) m_cnt = 0;
    else if (lu_cnt && m_cnt < 32'hFFFF) m_cnt++;
    m_ex = nx;
    #1;
    check_all();
  endtask

  task automatic idle();
    id_valid = 0; id_pc = 0; id_imm = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_reg_write = 0; id_mem_read = 0; id_ctrl = 0;
    rf_rdata1 = 0; rf_rdata2 = 0; ex_alu_result = 0; mem_rd = 0; mem_reg_write = 0;
    mem_fwd_data = 0; wb_rd = 0; wb_reg_write = 0; wb_data = 0; flush = 0; ex_hold = 0;
  endtask

  task automatic dec(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                     input logic u2, input logic [4:0] rd, input logic rw, input logic mr);
    id_valid = 1; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr;
    id_pc = id_pc + 32'd4; id_ctrl = id_ctrl + 12'd1; id_imm = $urandom;
  endtask

  logic [31:0] snap_pc;

  initial begin
    idle();
    rst = 1;
    m_ex = '{valid: 1'b0, pc: 32'd0, imm: 32'd0, op1: 32'd0, op2: 32'd0,
             rs1: 5'd0, rs2: 5'd0, rd: 5'd0, rw: 1'b0, mr: 1'b0, ctrl: 12'd0};
    m_cnt = 0;

    // Reset with a live decode instruction
    dec(5'd1, 1, 5'd2, 1, 5'd3, 1, 0);
    rf_rdata1 = 32'h1234;
    step(); step();
    check("rst_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_op1", ex_op1, 32'd0);
    check("rst_cnt", {16'd0, bubble_count}, 32'd0);
    check("rst_stall", {31'd0, stall_out}, 32'd0);
    rst = 0;
    idle();

    // EX forwarding
    dec(5'd0, 1, 5'd0, 0, 5'd5, 1, 0);
    step();
    ex_alu_result = 32'h11; rf_rdata1 = 32'hDEAD; rf_rdata2 = 32'hDEAD;
    dec(5'd5, 1, 5'd5, 1, 5'd6, 1, 0);
    step();
    check("ex_fwd_op1", ex_op1, 32'h11);
    check("ex_fwd_op2", ex_op2, 32'h11);

    // MEM over WB, WB alone, x0
    mem_rd = 7; mem_reg_write = 1; mem_fwd_data = 32'hA;
    wb_rd = 7; wb_reg_write = 1; wb_data = 32'hB;
    dec(5'd7, 1, 5'd0, 0, 5'd8, 1, 0);
    step();
    check("mem_over_wb", ex_op1, 32'hA);
    mem_reg_write = 0; rf_rdata1 = 32'h55;
    dec(5'd0, 1, 5'd7, 1, 5'd9, 1, 0);
    step();
    check("wb_fwd", ex_op2, 32'hB);
    check("x0_zero", ex_op1, 32'h0);
    idle();

    // Load-use: one bubble, then forward from MEM
    dec(5'd0, 0, 5'd0, 0, 5'd3, 1, 1);
    step();
    dec(5'd3, 1, 5'd0, 0, 5'd10, 1, 0);
    #1 check("lu_stall", {31'd0, stall_out}, 32'd1);
    step();
    check("lu_bubble", {31'd0, ex_valid}, 32'd0);
    check("lu_cnt", {16'd0, bubble_count}, 32'd1);
    check("lu_one_cycle", {31'd0, stall_out}, 32'd0);
    mem_rd = 3; mem_reg_write = 1; mem_fwd_data = 32'h1234;
    step();
    check("lu_mem_fwd", ex_op1, 32'h1234);
    check("lu_resume", {31'd0, ex_valid}, 32'd1);
    idle();

    // Flush wins over load-use
    dec(5'd0, 0, 5'd0, 0, 5'd4, 1, 1);
    step();
    dec(5'd0, 0, 5'd4, 1, 5'd11, 1, 0);
    flush = 1;
    #1 check("flush_no_stall", {31'd0, stall_out}, 32'd0);
    step();
    check("flush_bubble", {31'd0, ex_valid}, 32'd0);
    check("flush_cnt", {16'd0, bubble_count}, 32'd1);
    idle();

    // Hold freezes EX even with flush and changing decode
    dec(5'd1, 1, 5'd2, 1, 5'd12, 1, 0);
    step();
    snap_pc = m_ex.pc;
    for (int i = 0; i < 3; i++) begin
      ex_hold = 1; flush = 1;
      dec(5'($urandom_range(1, 31)), 1, 5'($urandom_range(1, 31)), 1, 5'd13, 1, 0);
      rf_rdata1 = $urandom; rf_rdata2 = $urandom;
      #1 check("hold_stall", {31'd0, stall_out}, 32'd1);
      step();
      check("hold_pc", ex_pc, snap_pc);
      check("hold_valid", {31'd0, ex_valid}, 32'd1);
    end
    idle();

    // Reset during a load-use stall
    dec(5'd0, 0, 5'd0, 0, 5'd6, 1, 1);
    step();
    dec(5'd6, 1, 5'd0, 0, 5'd7, 1, 0);
    rst = 1;
    step();
    check("rst_mid_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_mid_cnt", {16'd0, bubble_count}, 32'd0);
    rst = 0;
    step();
    check("rst_mid_restart", {31'd0, ex_valid}, 32'd1);

    // Randomized traffic, small register range to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 99) == 0);
      ex_hold       = ($urandom_range(0, 15) == 0);
      flush         = ($urandom_range(0, 9) == 0);
      id_valid      = ($urandom_range(0, 7) != 0);
      id_pc         = $urandom; id_imm = $urandom; id_ctrl = 12'($urandom);
      id_rs1        = 5'($urandom_range(0, 7));
      id_rs2        = 5'($urandom_range(0, 7));
      id_use_rs1    = 1'($urandom); id_use_rs2 = 1'($urandom);
      id_rd         = 5'($urandom_range(0, 7));
      id_reg_write  = ($urandom_range(0, 3) != 0);
      id_mem_read   = ($urandom_range(0, 2) == 0);
      rf_rdata1     = $urandom; rf_rdata2 = $urandom;
      ex_alu_result = $urandom;
      mem_rd        = 5'($urandom_range(0, 7)); mem_reg_write = 1'($urandom);
      mem_fwd_data  = $urandom;
      wb_rd         = 5'($urandom_range(0, 7)); wb_reg_write = 1'($urandom);
      wb_data       = $urandom;
      step();
    end

    // Saturation: preload the counter near the top, then add real bubbles
    idle();
    rst = 1;
    step();
    rst = 0;
    force dut.r_bubble_count = 16'hFFFD;
    #1 release dut.r_bubble_count;
    m_cnt = 32'hFFFD;
    for (int k = 0; k < 3; k++) begin
      dec(5'd0, 0, 5'd0, 0, 5'd2, 1, 1);
      step();
      dec(5'd2, 1, 5'd0, 0, 5'd0, 0, 0);
      step();
    end
    check("sat_cnt", {16'd0, bubble_count}, 32'h0000FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register that directly consumes the register file's two combinational read ports.
- Resolves RAW hazards by forwarding from the EX, MEM and WB stages, with priority EX > MEM > WB > register file.
- Detects load-use hazards: stalls the fetch/decode stages and inserts a bubble into EX.
- Handles branch flush and downstream hold, and counts inserted bubbles for performance monitoring.

Parameters:
- XLEN, 32, datapath width.
- CTRL_W, 12, width of the opaque decoded control bundle passed through to EX.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- id_valid  in  1  decode-stage instruction valid
- id_pc  in  XLEN  instruction PC
- id_imm  in  XLEN  decoded immediate
- id_rs1, id_rs2  in  5 each  source register indices; these also drive the register file read addresses
- id_use_rs1, id_use_rs2  in  1 each  instruction actually reads rs1/rs2
- id_rd  in  5  destination register index
- id_reg_write  in  1  instruction writes rd
- id_mem_read  in  1  instruction is a load
- id_ctrl  in  CTRL_W  decoded control bundle
- rf_rdata1, rf_rdata2  in  XLEN  register file read data
- ex_alu_result  in  XLEN  combinational result of the instruction currently in EX
- mem_rd  in  5  MEM-stage destination index
- mem_reg_write  in  1  MEM-stage write-enable
- mem_fwd_data  in  XLEN  MEM-stage result (load data for loads)
- wb_rd  in  5  WB-stage destination index (same as the register file write address)
- wb_reg_write  in  1  WB-stage write-enable
- wb_data  in  XLEN  WB-stage write data
- flush  in  1  taken branch/jump resolved in EX; kill the decode-stage instruction
- ex_hold  in  1  EX cannot accept (multi-cycle op); freeze
- stall_out  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid, ex_pc, ex_imm, ex_op1, ex_op2, ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_mem_read, ex_ctrl  out  registered EX-stage copies (op1/op2 are forwarded operands)
- bubble_count  out  16  saturating count of load-use bubbles

Behaviour:
- Reset: every registered output is 0 (ex_valid=0, all fields 0) and bubble_count=0. stall_out is 0 while rst=1.
- Latency: a decode instruction captured at edge N appears on the ex_* outputs after edge N.
- Operand select, evaluated per source s, independently for op1 and op2:
  - If s==0, the operand is 0; no forwarding.
  - Else if ex_valid && ex_reg_write && !ex_mem_read && ex_rd==s, use ex_alu_result.
  - Else if mem_reg_write && mem_rd==s, use mem_fwd_data.
  - Else if wb_reg_write && wb_rd==s, use wb_data. The register file commits at the same edge, so its read port is stale this cycle.
  - Else use rf_rdata.
- Load-use hazard (lu): ex_valid && ex_mem_read && ex_reg_write && ex_rd!=0 && id_valid && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
- Priority at each clock edge:
  1. rst: clear all registered outputs and bubble_count.
  2. ex_hold: all registers keep their values. stall_out=1. flush is ignored, because EX cannot resolve a branch while held.
  3. flush: load a bubble (ex_valid=0, ex_reg_write=0, ex_mem_read=0; other fields don't-care, driven 0). stall_out=0.
  4. lu: load a bubble; stall_out=1; bubble_count += 1, saturating at 0xFFFF.
  5. Otherwise: capture the decode fields and forwarded operands. ex_valid<=id_valid. ex_reg_write and ex_mem_read are gated by id_valid.
- stall_out = !rst && (ex_hold || (lu && !flush)).
- The instruction stalled by lu is re-presented by decode the next cycle. By then the load is in MEM and resolves through mem_fwd_data, so exactly one bubble is inserted per load-use.
- A load followed by a use two instructions later needs no stall; it forwards from MEM.
- A WB write to x0 is never forwarded. ex_op values for rs==0 are always 0, even if rf_rdata is non-zero.
- Asserting rst mid-stall clears everything. Decode restarts with no pending bubble.

Test Plan:
- Reset: hold rst=1 for 2 cycles with id_valid=1 → ex_valid=0, ex_op1=0, bubble_count=0, stall_out=0.
- EX forward: EX holds addi x5 with ex_alu_result=0x11; decode add x6,x5,x5 with rf_rdata1=rf_rdata2=0xDEAD → next cycle ex_op1=ex_op2=0x11.
- Priority and WB: mem_rd=wb_rd=7 with mem_fwd_data=0xA, wb_data=0xB, rs1=7 → ex_op1=0xA. With only WB matching (rs2=7, wb_data=0xB) → ex_op2=0xB. With rs1=0 and rf_rdata1=0x55 → ex_op1=0.
- Load-use: lw x3 in EX, decode uses rs1=3 → stall_out=1 for exactly 1 cycle, ex_valid=0 the next cycle, bubble_count=1. Following cycle: mem_fwd_data=0x1234 gives ex_op1=0x1234, ex_valid=1.
- Flush vs stall: lu condition and flush=1 in the same cycle → stall_out=0, ex_valid=0 next cycle, bubble_count unchanged.
- Hold: ex_hold=1 for 3 cycles with changing decode inputs and flush=1 → ex_* outputs frozen, stall_out=1. Saturation: force 0xFFFF+2 load-use bubbles → bubble_count=0xFFFF.
